// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through STAGES registers with stall back-propagation,
// bubbles, per-stage flush and exception kill. Define CTRL_PIPE_STATS_EN for stall/flush counters.
module ctrl_pipe_chain #(
  parameter int               WIDTH      = 16,
  parameter int               STAGES     = 3,
  parameter int               KILL_STAGE = 1,
  parameter logic [WIDTH-1:0] KILL_MASK  = 16'h0010
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ctrl_in,
  input  logic                     in_valid,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic                     exc_kill,
`ifdef CTRL_PIPE_STATS_EN
  input  logic                     stat_clr,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt,
`endif
  output logic [STAGES*WIDTH-1:0]  ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic [STAGES-1:0]        hold_out
);

  logic [STAGES-1:0]             hold_s;
  logic [STAGES-1:0]             upstream_hold_s;
  logic [STAGES-1:0][WIDTH-1:0]  word_r;
  logic [STAGES-1:0][WIDTH-1:0]  word_nxt_s;
  logic [STAGES-1:0][WIDTH-1:0]  pred_word_s;
  logic [STAGES-1:0]             valid_r;
  logic [STAGES-1:0]             valid_nxt_s;
  logic [STAGES-1:0]             pred_valid_s;
  logic [WIDTH-1:0]              in_word_s;

  // Invalid decode slots enter as all-zero words so an empty stage always reads zero.
  assign in_word_s       = in_valid ? ctrl_in : {WIDTH{1'b0}};
  assign pred_word_s     = {word_r[STAGES-2:0], in_word_s};
  assign pred_valid_s    = {valid_r[STAGES-2:0], in_valid};
  assign upstream_hold_s = {hold_s[STAGES-2:0], 1'b0};

  // Effective hold: a stall anywhere downstream freezes every stage upstream of it.
  always_comb begin : hold_chain
    logic acc;
    acc    = 1'b0;
    hold_s = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc       = acc | stall[i];
      hold_s[i] = acc;
    end
  end

  // Next state per stage: flush, then hold, then bubble behind a held stage, then load.
  always_comb begin
    word_nxt_s  = word_r;
    valid_nxt_s = valid_r;
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        word_nxt_s[i]  = {WIDTH{1'b0}};
        valid_nxt_s[i] = 1'b0;
      end else if (hold_s[i]) begin
        word_nxt_s[i]  = word_r[i];
        valid_nxt_s[i] = valid_r[i];
      end else if (upstream_hold_s[i]) begin
        word_nxt_s[i]  = {WIDTH{1'b0}};
        valid_nxt_s[i] = 1'b0;
      end else if ((i == KILL_STAGE) && pred_valid_s[i] && exc_kill) begin
        // Only the write enables are stripped; the instruction stays valid to reach commit.
        word_nxt_s[i]  = pred_word_s[i] & ~KILL_MASK;
        valid_nxt_s[i] = 1'b1;
      end else begin
        word_nxt_s[i]  = pred_word_s[i];
        valid_nxt_s[i] = pred_valid_s[i];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r  <= {(STAGES*WIDTH){1'b0}};
      valid_r <= {STAGES{1'b0}};
    end else begin
      word_r  <= word_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign ctrl_out  = word_r;
  assign valid_out = valid_r;
  assign hold_out  = hold_s;

`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        flush_hit_s;

  assign flush_hit_s = |(flush & valid_r);

  // Saturating event counters; stat_clr wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else if (stat_clr) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (hold_s[0] && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_hit_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: directed vector table, async reset sequence,
// randomized run against a behavioural model, and counter checks when CTRL_PIPE_STATS_EN is defined.
module tb_ctrl_pipe_chain;
  localparam int          WIDTH      = 16;
  localparam int          STAGES     = 3;
  localparam int          KILL_STAGE = 1;
  localparam logic [15:0] KMASK      = 16'h0010;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        ctrl_in;
  logic                    in_valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    exc_kill;
  logic [STAGES*WIDTH-1:0] ctrl_out;
  logic [STAGES-1:0]       valid_out;
  logic [STAGES-1:0]       hold_out;
`ifdef CTRL_PIPE_STATS_EN
  logic                    stat_clr;
  logic [31:0]             stall_cnt;
  logic [31:0]             flush_cnt;
`endif

  ctrl_pipe_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .KILL_STAGE(KILL_STAGE), .KILL_MASK(KMASK)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .in_valid(in_valid), .stall(stall), .flush(flush),
    .exc_kill(exc_kill),
`ifdef CTRL_PIPE_STATS_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .ctrl_out(ctrl_out), .valid_out(valid_out), .hold_out(hold_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: one word and valid flag per stage.
  logic [WIDTH-1:0] m_w [STAGES];
  logic             m_v [STAGES];

  task automatic model_clear();
    for (int i = 0; i < STAGES; i++) begin
      m_w[i] = '0;
      m_v[i] = 1'b0;
    end
  endtask

  function automatic logic [STAGES-1:0] m_hold(input logic [STAGES-1:0] st);
    logic [STAGES-1:0] h;
    for (int i = 0; i < STAGES; i++) h[i] = ((st >> i) != 0);
    return h;
  endfunction

  function automatic logic [STAGES*WIDTH-1:0] m_ctrl();
    logic [STAGES*WIDTH-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i*WIDTH +: WIDTH] = m_w[i];
    return r;
  endfunction

  function automatic logic [STAGES-1:0] m_valid();
    logic [STAGES-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i] = m_v[i];
    return r;
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] nw [STAGES];
    logic             nv [STAGES];
    logic [WIDTH-1:0] pw;
    logic             pv, held, up;
    for (int i = 0; i < STAGES; i++) begin
      held = ((stall >> i) != 0);
      up   = (i > 0) && ((stall >> (i - 1)) != 0);
      if (i == 0) begin
        pw = in_valid ? ctrl_in : 16'h0;
        pv = in_valid;
      end else begin
        pw = m_w[i-1];
        pv = m_v[i-1];
      end
      if (flush[i]) begin
        nw[i] = '0; nv[i] = 1'b0;
      end else if (held) begin
        nw[i] = m_w[i]; nv[i] = m_v[i];
      end else if (up) begin
        nw[i] = '0; nv[i] = 1'b0;
      end else begin
        nw[i] = (i == KILL_STAGE && pv && exc_kill) ? (pw & ~KMASK) : pw;
        nv[i] = pv;
      end
    end
    m_w = nw;
    m_v = nv;
  endtask

  // One clock: check hold before the edge, advance the model, compare after the edge.
  task automatic step(input string name);
    #1;
    check({name, "_hold"}, 64'(hold_out), 64'(m_hold(stall)));
    model_edge();
    @(posedge clk);
    #1;
    check({name, "_ctrl"}, 64'(ctrl_out), 64'(m_ctrl()));
    check({name, "_valid"}, 64'(valid_out), 64'(m_valid()));
  endtask

  typedef struct {
    logic [15:0] ci;
    logic        iv;
    logic [2:0]  st;
    logic [2:0]  fl;
    logic        k;
    logic [47:0] ec;
    logic [2:0]  ev;
    logic [2:0]  eh;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{16'h1234, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_0000_1234, 3'b001, 3'b000};
    tbl[1]  = '{16'h5678, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_1234_5678, 3'b011, 3'b000};
    tbl[2]  = '{16'h9ABC, 1'b1, 3'b000, 3'b000, 1'b0, 48'h1234_5678_9ABC, 3'b111, 3'b000};
    tbl[3]  = '{16'hDEF0, 1'b1, 3'b000, 3'b000, 1'b0, 48'h5678_9ABC_DEF0, 3'b111, 3'b000};
    tbl[4]  = '{16'h1111, 1'b1, 3'b010, 3'b000, 1'b0, 48'h0000_9ABC_DEF0, 3'b011, 3'b011};
    tbl[5]  = '{16'h1111, 1'b1, 3'b010, 3'b000, 1'b0, 48'h0000_9ABC_DEF0, 3'b011, 3'b011};
    tbl[6]  = '{16'h1111, 1'b1, 3'b000, 3'b000, 1'b0, 48'h9ABC_DEF0_1111, 3'b111, 3'b000};
    tbl[7]  = '{16'hFFFF, 1'b1, 3'b000, 3'b000, 1'b0, 48'hDEF0_1111_FFFF, 3'b111, 3'b000};
    tbl[8]  = '{16'h0000, 1'b0, 3'b000, 3'b000, 1'b1, 48'h1111_FFEF_0000, 3'b110, 3'b000};
    tbl[9]  = '{16'h0000, 1'b0, 3'b000, 3'b000, 1'b1, 48'hFFEF_0000_0000, 3'b100, 3'b000};
    tbl[10] = '{16'h2222, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_0000_2222, 3'b001, 3'b000};
    tbl[11] = '{16'h3333, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_2222_3333, 3'b011, 3'b000};
    tbl[12] = '{16'h4444, 1'b1, 3'b000, 3'b000, 1'b0, 48'h2222_3333_4444, 3'b111, 3'b000};
    tbl[13] = '{16'h5555, 1'b1, 3'b001, 3'b001, 1'b0, 48'h3333_0000_0000, 3'b100, 3'b001};
    tbl[14] = '{16'hFFFF, 1'b0, 3'b000, 3'b000, 1'b0, 48'h0000_0000_0000, 3'b000, 3'b000};
    tbl[15] = '{16'hFFFF, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_0000_FFFF, 3'b001, 3'b000};
    tbl[16] = '{16'h0000, 1'b0, 3'b010, 3'b000, 1'b1, 48'h0000_0000_FFFF, 3'b001, 3'b011};
    tbl[17] = '{16'h0000, 1'b0, 3'b000, 3'b010, 1'b1, 48'h0000_0000_0000, 3'b000, 3'b000};
    tbl[18] = '{16'hABCD, 1'b1, 3'b100, 3'b000, 1'b0, 48'h0000_0000_0000, 3'b000, 3'b111};
    tbl[19] = '{16'hABCD, 1'b1, 3'b000, 3'b000, 1'b0, 48'h0000_0000_ABCD, 3'b001, 3'b000};

    rst = 1'b1; ctrl_in = '0; in_valid = 1'b0; stall = '0; flush = '0; exc_kill = 1'b0;
`ifdef CTRL_PIPE_STATS_EN
    stat_clr = 1'b0;
`endif
    model_clear();
    #1;
    check("reset_ctrl", 64'(ctrl_out), 64'h0);
    check("reset_valid", 64'(valid_out), 64'h0);
    stall = 3'b100;
    #1;
    check("reset_hold", 64'(hold_out), 64'(3'b111));
    stall = 3'b000;
    @(posedge clk);
    #3;
    rst = 1'b0;

    for (int n = 0; n < 20; n++) begin
      ctrl_in = tbl[n].ci; in_valid = tbl[n].iv; stall = tbl[n].st;
      flush = tbl[n].fl; exc_kill = tbl[n].k;
      #1;
      check($sformatf("vec%0d_hold", n), 64'(hold_out), 64'(tbl[n].eh));
      model_edge();
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ctrl", n), 64'(ctrl_out), 64'(tbl[n].ec));
      check($sformatf("vec%0d_valid", n), 64'(valid_out), 64'(tbl[n].ev));
    end

    for (int n = 0; n < 400; n++) begin
      ctrl_in  = 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      flush    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      exc_kill = 1'($urandom);
      step($sformatf("rnd%0d", n));
    end

    // Asynchronous reset between edges with a full pipe.
    stall = '0; flush = '0; exc_kill = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      ctrl_in = 16'h7000 + 16'(n);
      step("fill");
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", 64'(ctrl_out), 64'h0);
    check("async_rst_valid", 64'(valid_out), 64'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ctrl_in = 16'hABCD;
    step("restart");
    check("restart_s0", 64'(ctrl_out), 64'h0000_0000_ABCD);

`ifdef CTRL_PIPE_STATS_EN
    stat_clr = 1'b1;
    step("sc_clr");
    stat_clr = 1'b0;
    check("stall_cnt_clr", 64'(stall_cnt), 64'd0);
    check("flush_cnt_clr", 64'(flush_cnt), 64'd0);
    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) step("sc_fill");
    stall = 3'b001;
    for (int n = 0; n < 5; n++) step("sc_stall");
    stall = 3'b000;
    check("stall_cnt_5", 64'(stall_cnt), 64'd5);
    for (int n = 0; n < 2; n++) step("sc_refill");
    flush = 3'b010;
    step("sc_fl1");
    flush = 3'b100;
    step("sc_fl2");
    flush = 3'b000;
    check("flush_cnt_2", 64'(flush_cnt), 64'd2);
    check("stall_cnt_keep", 64'(stall_cnt), 64'd5);
    stall = 3'b001; stat_clr = 1'b1;
    step("sc_clr_stall");
    stall = 3'b000; stat_clr = 1'b0;
    check("stall_cnt_clr_prio", 64'(stall_cnt), 64'd0);
    check("flush_cnt_clr_prio", 64'(flush_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
